// File: rtl/mux2t1x5_pkg.sv
// Shared datapath constants for the register-address selector.
//   REG_ADDR_W : width of a register-file address (default data width)
//   SEL_A0     : select encoding that picks the A0 input
//   SEL_A1     : select encoding that picks the A1 input
package mux2t1x5_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic SEL_A0 = 1'b0;
  localparam logic SEL_A1 = 1'b1;

endpackage

// File: rtl/mux2t1x5_mux2.sv
// Pure combinational two-to-one selector.
// Ports:
//   A0 : data chosen when S selects A0
//   A1 : data chosen when S selects A1
//   S  : select
//   Y  : selected data, same time step as any input change
module mux2
  import mux2t1x5_pkg::*;
#(
  parameter int unsigned WIDTH = REG_ADDR_W
) (
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic             S,
  output logic [WIDTH-1:0] Y
);

  // Conditional operator keeps the usual X-merge behaviour for an unknown select:
  // equal inputs pass through, differing bits go X.
  assign Y = (S == SEL_A1) ? A1 : A0;

endmodule

// File: rtl/mux2t1x5.sv
// Five-bit two-to-one selector with an optional registered copy of the result.
// Ports (positional order kept so legacy (A0, A1, S, Y) instances still bind):
//   A0  : data chosen when S = 0
//   A1  : data chosen when S = 1
//   S   : select
//   Y   : combinational selection, independent of clk and rst
//   clk : datapath clock, Y_q samples on the rising edge
//   rst : asynchronous active-high reset, clears Y_q only
//   Y_q : Y registered on the previous rising clk edge
module mux2t1x5
  import mux2t1x5_pkg::*;
#(
  parameter int unsigned WIDTH = REG_ADDR_W
) (
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic             S,
  output logic [WIDTH-1:0] Y,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] Y_q
);

  mux2 #(
    .WIDTH(WIDTH)
  ) u_mux2 (
    .A0(A0),
    .A1(A1),
    .S (S),
    .Y (Y)
  );

  // Reset has priority, so rst rising on a clock edge still leaves Y_q at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y_q <= '0;
    end else begin
      Y_q <= Y;
    end
  end

endmodule

// File: tb/tb_mux2t1x5.sv
module tb_mux2t1x5;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst;
  logic [W-1:0] a0, a1, y, y_q;
  logic         s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic         is_q;
    logic [W-1:0] exp;
  } item_t;

  item_t sb[$];
  event  chk_ev;

  mux2t1x5 #(.WIDTH(W)) dut (
    .A0 (a0),
    .A1 (a1),
    .S  (s),
    .Y  (y),
    .clk(clk),
    .rst(rst),
    .Y_q(y_q)
  );

  // Clock idles low until enabled.
  always #5 clk = clk_en ? ~clk : 1'b0;

  // Reference: index a two-entry table by the select value.
  function automatic logic [W-1:0] ref_sel(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                           input logic sel);
    logic [W-1:0] pair[2];
    pair[0] = x0;
    pair[1] = x1;
    return pair[sel];
  endfunction

  task automatic exp_y(input string name, input logic [W-1:0] e);
    sb.push_back('{name, 1'b0, e});
    -> chk_ev;
    #1;
  endtask

  task automatic exp_q(input string name, input logic [W-1:0] e);
    sb.push_back('{name, 1'b1, e});
    -> chk_ev;
    #1;
  endtask

  // Monitor: drains the scoreboard against the live DUT outputs.
  initial begin
    item_t        it;
    logic [W-1:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        it  = sb.pop_front();
        act = it.is_q ? y_q : y;
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", it.name, act, it.exp, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] captured;

    rst = 1'b1; a0 = '0; a1 = '0; s = 1'b0;
    #2;
    exp_q("reset_yq", 5'h00);
    rst = 1'b0;
    #1;

    // Toggle select with clock idle.
    a0 = 5'b00000; a1 = 5'b00001;
    for (int i = 0; i < 7; i++) begin
      s = i[0];
      exp_y("toggle_sel", ref_sel(a0, a1, s));
      #9;
    end

    // Full-width values.
    a0 = 5'h1F; a1 = 5'h0A; s = 1'b0;
    exp_y("full_s0", 5'h1F);
    s = 1'b1;
    exp_y("full_s1", 5'h0A);

    // Data change with select held.
    a1 = 5'h03;
    exp_y("hold_a1_03", 5'h03);
    a1 = 5'h1C;
    exp_y("hold_a1_1c", 5'h1C);
    a0 = 5'h15;
    exp_y("hold_a0_ignored", 5'h1C);
    exp_q("idle_clk_yq", 5'h00);

    // Registered path with mid-cycle select toggles and random data.
    clk_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      captured = ref_sel(a0, a1, s);
      #2;
      exp_q("reg_path", captured);
      s  = ~s;
      a0 = W'($urandom);
      if (i % 3 == 0) a1 = W'($urandom);
      exp_y("rand_y", ref_sel(a0, a1, s));
    end

    // Reset mid-operation.
    a1 = 5'h0A; s = 1'b1;
    @(posedge clk);
    #2;
    exp_q("pre_rst_yq", 5'h0A);
    rst = 1'b1;
    #1;
    exp_q("rst_async", 5'h00);
    exp_y("rst_y_unchanged", 5'h0A);
    @(posedge clk);
    #2;
    exp_q("rst_hold", 5'h00);
    rst = 1'b0;
    #1;
    exp_q("rst_release_wait", 5'h00);
    @(posedge clk);
    #2;
    exp_q("rst_release_load", 5'h0A);

    // Reset rising exactly on a clock edge.
    a0 = 5'h1F; s = 1'b0;
    @(posedge clk);
    rst = 1'b1;
    #2;
    exp_q("rst_at_edge", 5'h00);
    exp_y("rst_at_edge_y", 5'h1F);
    rst = 1'b0;
    @(posedge clk);
    #2;
    exp_q("after_edge_rst", 5'h1F);

    clk_en = 1'b0;
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
